// File: rtl/c_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : c_stream_serializer
// Description : Buffers N-lane vector beats of a result matrix in a 2-entry
//               FIFO and emits them one element per transfer, requantised by
//               a per-matrix right shift with saturation to OUT_WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module c_stream_serializer #(
  parameter int N            = 4,
  parameter int C_DATA_WIDTH = 18,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT_BITS   = $clog2(C_DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*C_DATA_WIDTH-1:0] in_data,
  input  logic [SHIFT_BITS-1:0]     shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_last_vec,
  output logic                      out_last_mat
);

  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LANE_W-1:0] c_LAST = LANE_W'(N - 1);

  // FIFO storage: data and the shift each entry must be requantised with
  logic [N*C_DATA_WIDTH-1:0] r_data  [2];
  logic [SHIFT_BITS-1:0]     r_shift [2];
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;

  logic [LANE_W-1:0]         r_lane;
  logic [LANE_W-1:0]         r_in_beat;
  logic [LANE_W-1:0]         r_out_beat;
  logic [SHIFT_BITS-1:0]     r_shift_hold;

  logic                      w_push;
  logic                      w_xfer;
  logic                      w_pop;
  logic [SHIFT_BITS-1:0]     w_entry_shift;
  logic [N*C_DATA_WIDTH-1:0] w_head;
  logic [C_DATA_WIDTH-1:0]   w_lane_val;
  logic [C_DATA_WIDTH-1:0]   w_shifted;
  logic [OUT_WIDTH-1:0]      w_requant;

  // Handshake qualifiers; in_ready never looks downstream, so no bypass path
  always_comb begin
    in_ready      = (r_count < 2'd2);
    out_valid     = (r_count != 2'd0);
    w_push        = in_valid & in_ready;
    w_xfer        = out_valid & out_ready;
    w_pop         = w_xfer & (r_lane == c_LAST);
    // Beat 0 of a matrix carries the live shift; later beats use the held copy
    w_entry_shift = (r_in_beat == '0) ? shift : r_shift_hold;
  end

  // Head-entry lane selection and right shift
  always_comb begin
    w_head     = r_data[r_rd_ptr];
    w_lane_val = w_head[r_lane*C_DATA_WIDTH +: C_DATA_WIDTH];
    w_shifted  = w_lane_val >> r_shift[r_rd_ptr];
  end

  // Saturation only exists when the output is narrower than the input
  generate
    if (OUT_WIDTH < C_DATA_WIDTH) begin : g_sat
      logic w_over;
      // Any bit above the output width means the value does not fit
      always_comb begin
        w_over    = |w_shifted[C_DATA_WIDTH-1:OUT_WIDTH];
        w_requant = w_over ? {OUT_WIDTH{1'b1}} : w_shifted[OUT_WIDTH-1:0];
      end
    end else begin : g_no_sat
      // Zero-extend; every input value fits
      always_comb begin
        w_requant = OUT_WIDTH'(w_shifted);
      end
    end
  endgenerate

  // Outputs are forced to zero whenever nothing is buffered
  always_comb begin
    out_data     = out_valid ? w_requant : '0;
    out_last_vec = out_valid & (r_lane == c_LAST);
    out_last_mat = out_valid & (r_lane == c_LAST) & (r_out_beat == c_LAST);
  end

  // Control state: occupancy, pointers, lane and beat counters, held shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_lane       <= '0;
      r_in_beat    <= '0;
      r_out_beat   <= '0;
      r_shift_hold <= '0;
    end else begin
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
      if (w_push) begin
        r_wr_ptr  <= ~r_wr_ptr;
        r_in_beat <= (r_in_beat == c_LAST) ? '0 : r_in_beat + 1'b1;
        if (r_in_beat == '0) begin
          r_shift_hold <= shift;
        end
      end
      if (w_xfer) begin
        r_lane <= (r_lane == c_LAST) ? '0 : r_lane + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_out_beat <= (r_out_beat == c_LAST) ? '0 : r_out_beat + 1'b1;
      end
    end
  end

  // Payload storage; contents are only observed while counted as occupied
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr]  <= in_data;
      r_shift[r_wr_ptr] <= w_entry_shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_c_stream_serializer
// Description : Self-checking bench; an element-level reference queue predicts
//               every output, readiness and validity on each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c_stream_serializer;

  localparam int N  = 4;
  localparam int CW = 18;
  localparam int OW = 8;
  localparam int SB = $clog2(CW);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N*CW-1:0]   in_data;
  logic [SB-1:0]     shift;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              out_last_vec;
  logic              out_last_mat;

  c_stream_serializer #(
    .N(N), .C_DATA_WIDTH(CW), .OUT_WIDTH(OW), .SHIFT_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_vec(out_last_vec), .out_last_mat(out_last_mat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected element stream: {last_mat, last_vec, data}
  logic [OW+1:0] q[$];
  int            m_beat  = 0;
  int            m_shift = 0;
  int            emitted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Append the N elements of an accepted beat, computed from the matrix rules
  task automatic model_push(input logic [N*CW-1:0] d, input logic [SB-1:0] sh);
    int v;
    if (m_beat == 0) m_shift = int'(sh);
    for (int l = 0; l < N; l++) begin
      v = int'(d[l*CW +: CW]) >>> m_shift;
      if (v > (1 << OW) - 1) v = (1 << OW) - 1;
      q.push_back({(m_beat * N + l) == N * N - 1, l == N - 1, OW'(v)});
    end
    m_beat = (m_beat + 1) % N;
  endtask

  // One clock cycle: drive, check against the model, advance the model
  task automatic step(input bit iv, input logic [N*CW-1:0] d, input logic [SB-1:0] sh,
                      input bit ordy, output bit pushed);
    int  occ;
    bit  popping;
    in_valid  = iv;
    in_data   = d;
    shift     = sh;
    out_ready = ordy;
    #1;
    occ = (q.size() + N - 1) / N;
    chk("in_ready", in_ready, occ < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0][OW-1:0]);
      chk("out_last_vec", out_last_vec, q[0][OW]);
      chk("out_last_mat", out_last_mat, q[0][OW+1]);
    end else begin
      chk("idle_data", {out_data, out_last_vec, out_last_mat}, 0);
    end
    pushed  = iv && (occ < 2);
    popping = (q.size() > 0) && ordy;
    @(posedge clk);
    if (popping) begin
      void'(q.pop_front());
      emitted++;
    end
    if (pushed) model_push(d, sh);
    @(negedge clk);
  endtask

  // Offer one beat until accepted; valid may be randomly withheld
  task automatic offer(input logic [N*CW-1:0] d, input logic [SB-1:0] sh,
                       input bit rnd_v, input bit rnd_r, input bit ordy);
    bit pushed;
    int budget;
    pushed = 0;
    budget = 0;
    while (!pushed && budget < 200) begin
      step(rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1, d, sh,
           rnd_r ? ($urandom_range(0, 2) != 0) : ordy, pushed);
      budget++;
    end
    if (!pushed) chk("offer_timeout", 1, 0);
  endtask

  task automatic drain(input bit rnd_r);
    bit pushed;
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 500) begin
      step(1'b0, '0, '0, rnd_r ? ($urandom_range(0, 1) != 0) : 1'b1, pushed);
      budget++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  function automatic logic [N*CW-1:0] pack(input int a, input int b, input int c, input int e);
    logic [N*CW-1:0] r;
    r = '0;
    r[0*CW +: CW] = CW'(a);
    r[1*CW +: CW] = CW'(b);
    r[2*CW +: CW] = CW'(c);
    r[3*CW +: CW] = CW'(e);
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_outs"}, {out_valid, out_data, out_last_vec, out_last_mat}, 0);
  endtask

  initial begin
    bit              pushed;
    logic [N*CW-1:0] d;
    int              start;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    shift     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    step(1'b0, '0, '0, 1'b1, pushed);

    // Elements 1..16, shift 0, downstream always ready
    start = emitted;
    for (int b = 0; b < N; b++)
      offer(pack(4*b+1, 4*b+2, 4*b+3, 4*b+4), '0, 1'b0, 1'b0, 1'b1);
    drain(1'b0);
    chk("m1_count", emitted - start, 16);

    // Saturation: shift 4 sampled at beat 0, live shift changed afterwards
    d = pack(32'h3FFFF, 32'h0FF0, 32'h10, 32'h0F);
    for (int b = 0; b < N; b++)
      offer(d, (b == 0) ? SB'(4) : SB'(0), 1'b0, 1'b0, 1'b1);
    drain(1'b0);

    // Back-pressure: only two beats fit, head stays on lane 0 of beat 0
    for (int b = 0; b < 2; b++)
      offer(pack(4*b+1, 4*b+2, 4*b+3, 4*b+4), '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, pack(9, 10, 11, 12), '0, 1'b0, pushed);
    chk("bp_blocked", pushed, 0);
    chk("bp_head", out_data, 1);
    start = emitted;
    offer(pack(9, 10, 11, 12), '0, 1'b0, 1'b0, 1'b1);
    offer(pack(13, 14, 15, 16), '0, 1'b0, 1'b0, 1'b1);
    drain(1'b0);
    chk("bp_count", emitted - start, 16);

    // Randomised traffic over 8 matrices
    start = emitted;
    for (int m = 0; m < 8; m++) begin
      for (int b = 0; b < N; b++) begin
        for (int l = 0; l < N; l++)
          d[l*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1) >> $urandom_range(0, CW - 1));
        offer(d, SB'($urandom_range(0, 12)), 1'b1, 1'b1, 1'b1);
      end
    end
    drain(1'b1);
    chk("rand_count", emitted - start, 8 * 16);

    // Reset after 6 elements of a matrix
    for (int b = 0; b < 2; b++)
      offer(pack(4*b+1, 4*b+2, 4*b+3, 4*b+4), '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, '0, '0, 1'b1, pushed);
    chk("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    q.delete();
    m_beat = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, '0, '0, 1'b1, pushed);
    start = emitted;
    for (int b = 0; b < N; b++)
      offer(pack(4*b+101, 4*b+102, 4*b+103, 4*b+104), SB'(b), 1'b0, 1'b0, 1'b1);
    drain(1'b0);
    chk("post_reset_count", emitted - start, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
